// File: rtl/axis_crc32_arbiter_if.sv
// Bundle of requester, response and engine streams for the shared CRC32 arbiter.
// The slave view is the arbiter itself; the master view is its environment
// (requesters, response sinks and the CRC engine).
interface axis_crc32_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DW      = 32
);
   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]    req_tvalid;
   logic [NUM_REQ-1:0]    req_tready;
   logic [NUM_REQ*DW-1:0] req_tdata;
   logic [NUM_REQ-1:0]    rsp_tvalid;
   logic [NUM_REQ-1:0]    rsp_tready;
   logic [DW-1:0]         rsp_tdata;
   logic                  rsp_terr;
   logic                  eng_tvalid;
   logic                  eng_tready;
   logic [DW-1:0]         eng_tdata;
   logic                  res_tvalid;
   logic                  res_tready;
   logic [DW-1:0]         res_tdata;
   logic                  busy;
   logic [GW-1:0]         grant_id;
   logic                  timeout_err;

   modport slave (
      input  req_tvalid, req_tdata, rsp_tready, eng_tready, res_tvalid, res_tdata,
      output req_tready, rsp_tvalid, rsp_tdata, rsp_terr, eng_tvalid, eng_tdata,
             res_tready, busy, grant_id, timeout_err
   );

   modport master (
      output req_tvalid, req_tdata, rsp_tready, eng_tready, res_tvalid, res_tdata,
      input  req_tready, rsp_tvalid, rsp_tdata, rsp_terr, eng_tvalid, eng_tdata,
             res_tready, busy, grant_id, timeout_err
   );
endinterface

// File: rtl/axis_crc32_arbiter.sv
// Round-robin arbiter sharing one CRC32 engine among NUM_REQ single-word
// requesters. One word is in flight at a time; the engine result (or a
// timeout abort) is returned only to the requester that was granted.
module axis_crc32_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input logic                 aclk,
   input logic                 areset,
   axis_crc32_arbiter_if.slave bus
);
   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCEPT,
      S_SEND,
      S_WAIT,
      S_RESP
   } state_t;

   state_t                    state_q;
   logic [GW-1:0]             grant_q;
   logic [GW-1:0]             last_q;
   logic [AXI_DATA_WIDTH-1:0] buf_q;
   logic [AXI_DATA_WIDTH-1:0] rsp_data_q;
   logic                      rsp_err_q;
   logic [CW-1:0]             cnt_q;
   logic                      tmo_q;

   logic [GW-1:0]             grant_d;
   logic [GW-1:0]             idx;
   logic [AXI_DATA_WIDTH-1:0] sel_word;

   // Round-robin pick: scan from last_q+1 upward with wrap; the nearest
   // valid requester wins because it is written last.
   always_comb begin
      grant_d = '0;
      idx     = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         idx = GW'((int'(last_q) + i) % NUM_REQ);
         if (bus.req_tvalid[idx]) grant_d = idx;
      end
   end

   // Select the granted requester's data lane.
   always_comb begin
      sel_word = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q == GW'(i)) sel_word = bus.req_tdata[AXI_DATA_WIDTH*i +: AXI_DATA_WIDTH];
      end
   end

   // Per-requester handshake decodes, one-hot on the current grant.
   always_comb begin
      bus.req_tready = '0;
      bus.rsp_tvalid = '0;
      if (state_q == S_ACCEPT) bus.req_tready[grant_q] = 1'b1;
      if (state_q == S_RESP)   bus.rsp_tvalid[grant_q] = 1'b1;
   end

   assign bus.eng_tvalid  = (state_q == S_SEND);
   assign bus.eng_tdata   = buf_q;
   assign bus.res_tready  = (state_q == S_WAIT);
   assign bus.rsp_tdata   = rsp_data_q;
   assign bus.rsp_terr    = rsp_err_q;
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.grant_id    = grant_q;
   assign bus.timeout_err = tmo_q;

   // Transaction FSM: arbitrate, take the word, feed the engine, wait for the
   // result with a watchdog, then hold the response until the owner takes it.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q    <= S_IDLE;
         grant_q    <= '0;
         last_q     <= GW'(NUM_REQ - 1);
         buf_q      <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         cnt_q      <= '0;
         tmo_q      <= 1'b0;
      end else begin
         tmo_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (|bus.req_tvalid) begin
                  grant_q <= grant_d;
                  state_q <= S_ACCEPT;
               end
            end
            S_ACCEPT: begin
               // A requester that drops valid here is simply waited for.
               if (bus.req_tvalid[grant_q]) begin
                  buf_q   <= sel_word;
                  state_q <= S_SEND;
               end
            end
            S_SEND: begin
               if (bus.eng_tready) begin
                  cnt_q   <= '0;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               // A result on the terminal-count cycle takes priority over the abort.
               if (bus.res_tvalid) begin
                  rsp_data_q <= bus.res_tdata;
                  rsp_err_q  <= 1'b0;
                  state_q    <= S_RESP;
               end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                  tmo_q      <= 1'b1;
                  rsp_data_q <= '0;
                  rsp_err_q  <= 1'b1;
                  state_q    <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_RESP: begin
               if (bus.rsp_tready[grant_q]) begin
                  last_q  <= grant_q;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: doc/axis_crc32_arbiter.md
Name: axis_crc32_arbiter

Overview:
- Shares one axis_crc32_mpeg2 engine among NUM_REQ AXI-Stream requesters.
- Each requester submits single 32-bit words. The block grants one requester at a time (round-robin), forwards its word to the engine, waits for the CRC result, and returns the result to that requester only.
- Sits between client streams and the engine's s_axis/m_axis. Detects a hung engine with a timeout.

Parameters:
- NUM_REQ, 4: number of requesters (1..16).
- AXI_DATA_WIDTH, 32: word width. Must be 32, to match the engine.
- TIMEOUT_CYCLES, 256: maximum cycles in WAIT_RES before abort (>=40).
- GW: derived, max(1, $clog2(NUM_REQ)).

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous, active-high reset
- req_tvalid  in  NUM_REQ  per-requester word valid
- req_tready  out  NUM_REQ  per-requester word ready
- req_tdata  in  NUM_REQ*32  requester i uses bits [32*i+31:32*i]
- rsp_tvalid  out  NUM_REQ  one-hot result valid
- rsp_tready  in  NUM_REQ  per-requester result ready
- rsp_tdata  out  32  result word, shared bus (qualified by rsp_tvalid)
- rsp_terr  out  1  result is a timeout abort (valid with rsp_tvalid)
- eng_tvalid  out  1  to engine s_axis.tvalid
- eng_tready  in  1  from engine s_axis.tready
- eng_tdata  out  32  to engine s_axis.tdata
- res_tvalid  in  1  from engine m_axis.tvalid
- res_tready  out  1  to engine m_axis.tready
- res_tdata  in  32  from engine m_axis.tdata
- busy  out  1  high in any state except IDLE
- grant_id  out  GW  index of the current or last granted requester
- timeout_err  out  1  one-cycle pulse on abort

Behaviour:
- Reset is asynchronous and active-high, applied on areset assertion at any time, including mid-transaction. All outputs go to 0, FSM goes to IDLE, last_grant = NUM_REQ-1 (so requester 0 wins first), timeout counter = 0. Any in-flight word is discarded.
- States: IDLE, ACCEPT, SEND, WAIT_RES, RESP. All outputs are registered or decoded from state and grant; no input-to-output combinational paths except req_tready/rsp_tvalid decode.
- IDLE:
  - If any req_tvalid is set, grant the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Register grant into grant_id and go to ACCEPT.
  - Otherwise stay in IDLE.
- ACCEPT:
  - req_tready[grant]=1; all other req_tready bits = 0.
  - On req_tvalid[grant]: latch the word into buf and go to SEND.
  - If valid has dropped (protocol violation), hold in ACCEPT.
- SEND:
  - eng_tvalid=1, eng_tdata=buf, held stable until eng_tready.
  - On eng_tvalid & eng_tready: go to WAIT_RES and clear the timeout counter.
  - Latency from req handshake to eng_tvalid high: 1 cycle.
- WAIT_RES:
  - res_tready=1.
  - On res_tvalid: latch res_tdata into rsp_tdata, rsp_terr=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES-1 without res_tvalid: pulse timeout_err, set rsp_tdata=0, rsp_terr=1, go to RESP.
  - If res_tvalid arrives in the same cycle as the terminal count, the result wins and there is no error.
- RESP:
  - rsp_tvalid[grant]=1 (one-hot), rsp_tdata/rsp_terr held stable.
  - On rsp_tready[grant]: set last_grant=grant and go to IDLE.
  - Other requesters' rsp_tready are ignored.
- Fairness: a requester holding req_tvalid continuously is served at least once every NUM_REQ transactions. Requests arriving during a transaction only compete in the next IDLE arbitration.
- busy=1 in ACCEPT, SEND, WAIT_RES and RESP.
- res_tready stays 0 outside WAIT_RES. A late engine result after a timeout is therefore held by the engine and consumed by the next transaction. The bench checks this behaviour; the system prevents it by sizing TIMEOUT_CYCLES.
- Minimum turnaround per word with a zero-latency engine and always-ready sinks: 5 cycles.
- NUM_REQ=1: arbitration degenerates and grant_id is constantly 0.

Test Plan:
- Single request, stub engine (result = data ^ 0xA5A5A5A5, 34-cycle latency):
  - Stimulus: req0 sends 0x12345678.
  - Required: eng_tdata=0x12345678 one cycle after the req0 handshake; rsp_tvalid=4'b0001, rsp_tdata=0xB791F3DD, rsp_terr=0; busy falls after rsp_tready.
- Round-robin, all four requesters valid from reset, each with a distinct word:
  - Required: grants in order 0,1,2,3,0. Each rsp_tvalid is one-hot for the correct index and carries data^0xA5A5A5A5.
- Backpressure:
  - Stimulus: eng_tready delayed 5 cycles, res stalled 10 cycles, rsp_tready[2] low for 7 cycles.
  - Required: eng_tdata and rsp_tdata stay stable during the stalls; no duplicate or lost transfers.
- Timeout, stub engine never asserts res_tvalid, TIMEOUT_CYCLES=40:
  - Required: timeout_err pulses exactly once, 40 cycles after entering WAIT_RES; the requester receives rsp_tdata=0, rsp_terr=1; the FSM returns to IDLE.
- Reset mid-operation:
  - Stimulus: areset asserted asynchronously (between clock edges) during SEND, then released.
  - Required: all outputs 0 immediately; after release, req0 is granted first; no response is produced for the aborted word.
- Result/timeout race:
  - Stimulus: res_tvalid asserted exactly on the terminal count cycle.
  - Required: rsp_terr=0, correct result delivered, timeout_err stays 0.
